// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and types.
// Address width, reset vector and fetch step for the fetch path.
package cpu_pkg;

  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000;
  localparam int unsigned INST_STEP = 4;

  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/pc_incr.sv
// Combinational fetch-address incrementer (pc + STEP).
// Shared with the branch-target logic.
module pc_incr #(
  parameter int          WIDTH = cpu_pkg::ADDR_W,
  parameter int unsigned STEP  = cpu_pkg::INST_STEP
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] y_o
);

  // Wraps modulo 2**WIDTH at the top of the address space.
  assign y_o = a_i + WIDTH'(STEP);

endmodule

// File: rtl/program_counter.sv
// Free-running sequential fetch program counter.
// Drives the instruction ROM address and chip enable.
module program_counter #(
  parameter int               WIDTH        = cpu_pkg::ADDR_W,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(cpu_pkg::RESET_VECTOR),
  parameter int unsigned      STEP         = cpu_pkg::INST_STEP
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] pc,
  output logic             inst_ce
);

  if (STEP == 0) begin : g_bad_step
    $fatal(1, "program_counter: STEP must be nonzero");
  end

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_inc;
  logic             ce_q;

  pc_incr #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_incr (
    .a_i (pc_q),
    .y_o (pc_inc)
  );

  // First enabled cycle fetches the reset vector itself.
  always_comb begin
    pc_d = RESET_VECTOR;
    if (ce_q) pc_d = pc_inc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_VECTOR;
      ce_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      ce_q <= 1'b1;
    end
  end

  assign pc      = pc_q;
  assign inst_ce = ce_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter.
// Three parameter variants share one clock and reset.
module tb_program_counter;

  logic        clk;
  logic        rst;
  logic [31:0] pc_a;
  logic        ce_a;
  logic [31:0] pc_w;
  logic        ce_w;
  logic [15:0] pc_h;
  logic        ce_h;

  int checks = 0;
  int errors = 0;
  int n_act  = 0;
  bit cmp_en = 0;

  localparam logic [31:0] RV_A = 32'h0000_0000;
  localparam logic [31:0] RV_W = 32'hFFFF_FFF8;
  localparam logic [31:0] RV_H = 32'h0000_0100;

  program_counter dut_a (
    .clk     (clk),
    .rst     (rst),
    .pc      (pc_a),
    .inst_ce (ce_a)
  );

  program_counter #(
    .RESET_VECTOR (32'hFFFF_FFF8)
  ) dut_w (
    .clk     (clk),
    .rst     (rst),
    .pc      (pc_w),
    .inst_ce (ce_w)
  );

  program_counter #(
    .WIDTH        (16),
    .STEP         (2),
    .RESET_VECTOR (16'h0100)
  ) dut_h (
    .clk     (clk),
    .rst     (rst),
    .pc      (pc_h),
    .inst_ce (ce_h)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Model: number of clock edges seen out of reset since last release.
  always @(posedge clk or negedge rst) begin
    if (!rst) n_act = 0;
    else      n_act = n_act + 1;
  end

  function automatic logic [31:0] exp_pc(
    input logic [31:0] rv, input int step, input int w, input int n);
    logic [63:0] v;
    logic [63:0] m;
    v = {32'h0, rv};
    if (n > 0) v = v + 64'(step) * 64'(n - 1);
    m = (64'h1 << w) - 64'h1;
    return 32'(v & m);
  endfunction

  function automatic logic exp_ce(input int n);
    return n > 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_model(input string tag);
    check({tag, " pc_a"}, pc_a, exp_pc(RV_A, 4, 32, n_act));
    check({tag, " ce_a"}, 32'(ce_a), 32'(exp_ce(n_act)));
    check({tag, " pc_w"}, pc_w, exp_pc(RV_W, 4, 32, n_act));
    check({tag, " ce_w"}, 32'(ce_w), 32'(exp_ce(n_act)));
    check({tag, " pc_h"}, {16'h0, pc_h}, exp_pc(RV_H, 2, 16, n_act));
    check({tag, " ce_h"}, 32'(ce_h), 32'(exp_ce(n_act)));
  endtask

  always @(negedge clk) begin
    if (cmp_en) check_all_model("cyc");
  end

  logic [31:0] seq_a [4];
  logic [31:0] seq_w [4];
  logic [31:0] seq_h [4];

  initial begin
    seq_a = '{32'h0, 32'h4, 32'h8, 32'hC};
    seq_w = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    seq_h = '{32'h0100, 32'h0102, 32'h0104, 32'h0106};

    // power-up reset
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("por pc_a", pc_a, 32'h0);
    check("por ce_a", 32'(ce_a), 32'h0);
    check("por pc_w", pc_w, 32'hFFFF_FFF8);
    check("por pc_h", {16'h0, pc_h}, 32'h0100);
    cmp_en = 1;
    #998;

    // release between edges, count 10 edges
    #5 rst = 1'b1;
    @(posedge clk); #1;
    check("first ce_a", 32'(ce_a), 32'h1);
    check("first pc_a", pc_a, 32'h0);
    repeat (9) @(posedge clk);
    #1;
    check("10 edges pc_a", pc_a, 32'h24);
    check("model 10", exp_pc(RV_A, 4, 32, n_act), 32'h24);
    repeat (7) @(posedge clk);
    #1;
    check("mid pc_a", pc_a, 32'h40);

    // async reset between edges
    #4 rst = 1'b0;
    #1;
    check("async pc_a", pc_a, 32'h0);
    check("async ce_a", 32'(ce_a), 32'h0);
    check("async pc_w", pc_w, 32'hFFFF_FFF8);
    check("async pc_h", {16'h0, pc_h}, 32'h0100);
    #49 rst = 1'b1;

    // restart sequences, incl. wrap and 16-bit variant
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("seq_a[%0d]", i), pc_a, seq_a[i]);
      check($sformatf("seq_w[%0d]", i), pc_w, seq_w[i]);
      check($sformatf("seq_h[%0d]", i), {16'h0, pc_h}, seq_h[i]);
      check($sformatf("seq_ce[%0d]", i), 32'(ce_h), 32'h1);
    end

    // release coincident with a rising edge
    @(posedge clk);
    #5 rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    rst <= 1'b1;
    #1;
    check("edge rel ce_a", 32'(ce_a), 32'h0);
    check("edge rel pc_w", pc_w, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    check("edge next ce_a", 32'(ce_a), 32'h1);
    check("edge next pc_w", pc_w, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    check("edge 2nd pc_w", pc_w, 32'hFFFF_FFFC);
    repeat (4) @(posedge clk);
    @(negedge clk);
    cmp_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
